core_host_seq: RTL
==================

Name: core_host_seq

Overview:
- Host-side initiator for the main_core command/data interface; drives what the bench drives by hand today.
- Consumes one upstream 64-bit word stream of headers plus payload, and issues main_core commands.
- Forwards write payload into the core's input, and returns core output words upstream.
- Sits between the external host link (UART/AXI bridge) and main_core.

Parameters:
CMD_W, 16, width of main_core cmd field (= `MainCoreCMD_which_SIZE+`MainCoreCMD_SIZE); legal range 1..32
CNT_W, 16, width of payload word counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
host_in  input  64  upstream header/payload word
host_in_isReady  input  1  host_in valid
host_in_canReceive  output  1  block accepts host_in this cycle
host_out  output  64  upstream response word
host_out_isReady  output  1  host_out valid
host_out_canReceive  input  1  host accepts host_out
cmd  output  CMD_W  command to main_core
cmd_hasAny  output  1  cmd valid
cmd_consume  input  1  core takes cmd
core_in  output  64  word to main_core in
core_in_isReady  output  1  core_in valid
core_in_canReceive  input  1  core accepts core_in
core_out  input  64  word from main_core out
core_out_isReady  input  1  core_out valid
core_out_canReceive  output  1  block accepts core_out
busy  output  1  state != IDLE

Behaviour:
- Clock is clk; reset rst is synchronous, active-high; one clock domain.
- Transfer rule: a word moves on a rising edge where valid & ready are both 1. For cmd, valid is cmd_hasAny and ready is cmd_consume.
- Header format:
  - [63:62] kind: 00 CMD, 01 WRITE, 10 READ, 11 SYNC.
  - [47:32] count; the low CNT_W bits are used.
  - [CMD_W-1:0] cmd value.
  - All other bits are ignored.
- States: IDLE, CMD, WRITE, READ, SYNC.
- IDLE:
  - host_in_canReceive=1; all other handshake outputs are 0.
  - Header accepted -> CMD / WRITE / READ / SYNC on the next edge.
  - WRITE or READ with count=0: stay IDLE; counts as a completed transaction.
- CMD:
  - cmd holds the header cmd field; cmd_hasAny=1.
  - On the cmd_consume transfer edge -> IDLE.
  - cmd is driven to 0 whenever cmd_hasAny=0.
- WRITE: combinational pass-through.
  - core_in=host_in, core_in_isReady=host_in_isReady, host_in_canReceive=core_in_canReceive.
  - remaining counter decrements per transfer; the transfer with remaining=1 -> IDLE.
  - Zero added latency; no buffering.
- READ: combinational pass-through.
  - host_out=core_out, host_out_isReady=core_out_isReady, core_out_canReceive=host_out_canReceive.
  - Same counting as WRITE.
  - host_in_canReceive=0, so no header lookahead.
- SYNC:
  - host_out={16'hA5A5, 16'h0000, 16'b0, txn_count}; host_out_isReady=1.
  - On transfer -> IDLE.
  - Reported txn_count excludes the SYNC itself; it increments after the SYNC is sent.
- txn_count: 16-bit internal counter; +1 on each completed transaction (CMD consumed, final WRITE/READ word, zero-count header, SYNC sent); wraps 0xFFFF->0.
- Outside the active state, host_out=0 and core_in=0.
- Reset:
  - State -> IDLE, counters -> 0, all outputs 0 except host_in_canReceive=1 the cycle after reset.
  - A pending cmd or partial WRITE/READ is abandoned, with no completion count.
- Only one transaction is in flight at a time; a header is never accepted outside IDLE.

Test Plan:
- Reset, then CMD header cmd=16'h0123 with core holding cmd_consume=0 for 3 cycles -> cmd_hasAny=1 and cmd=0x0123 stable for 4 cycles; IDLE the cycle after consume; host_in_canReceive=1 again.
- WRITE count=3, payload 0x11..,0x22..,0x33..; core_in_canReceive toggles 1,0,1,0,1 -> core sees exactly the three words in order; the 4th host word is not accepted until IDLE and is parsed as a header.
- READ count=2; core presents 0xAAAA...,0xBBBB...; host_out_canReceive held 0 for 2 cycles first -> no transfer while stalled; both words delivered in order; busy drops after the 2nd.
- WRITE count=0, then SYNC -> no core_in activity; SYNC word = 0xA5A5_0000_0000_0001.
- Reset asserted mid-WRITE after 1 of 4 words -> next cycle: all handshake outputs 0, host_in_canReceive=1; a following SYNC reports txn_count=0.
- 0xFFFF zero-count WRITE headers, then 2 SYNCs -> first reports 0xFFFF, second reports 0x0000 (wrap).

Source files
------------

// File: rtl/core_host_seq.sv
// Host-side initiator for main_core: parses header words from the host stream and
// issues commands, forwards write payload, returns read data, and answers SYNC probes.
module core_host_seq #(
    parameter int CMD_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      host_in,
    input  logic             host_in_isReady,
    output logic             host_in_canReceive,
    output logic [63:0]      host_out,
    output logic             host_out_isReady,
    input  logic             host_out_canReceive,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_hasAny,
    input  logic             cmd_consume,
    output logic [63:0]      core_in,
    output logic             core_in_isReady,
    input  logic             core_in_canReceive,
    input  logic [63:0]      core_out,
    input  logic             core_out_isReady,
    output logic             core_out_canReceive,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WRITE,
        S_READ,
        S_SYNC
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CMD_W-1:0] cmd_q;
    logic [CNT_W-1:0] remaining;
    logic [15:0]      txn_count;

    logic             hdr_take;
    logic             word_xfer;
    logic             done;
    logic [1:0]       hdr_kind;
    logic [CNT_W-1:0] hdr_count;
    logic             unused_hdr_bits;

    assign hdr_kind        = host_in[63:62];
    assign hdr_count       = CNT_W'(host_in[47:32]);
    assign unused_hdr_bits = ^host_in;
    assign busy            = (state != S_IDLE);

    always_comb begin
        state_nx            = state;
        hdr_take            = 1'b0;
        word_xfer           = 1'b0;
        done                = 1'b0;
        host_in_canReceive  = 1'b0;
        host_out            = '0;
        host_out_isReady    = 1'b0;
        cmd                 = '0;
        cmd_hasAny          = 1'b0;
        core_in             = '0;
        core_in_isReady     = 1'b0;
        core_out_canReceive = 1'b0;

        case (state)
            S_IDLE: begin
                host_in_canReceive = 1'b1;
                if (host_in_isReady) begin
                    hdr_take = 1'b1;
                    // zero-length WRITE/READ completes on the header itself
                    case (hdr_kind)
                        2'b00: state_nx = S_CMD;
                        2'b01: if (hdr_count == '0) done = 1'b1; else state_nx = S_WRITE;
                        2'b10: if (hdr_count == '0) done = 1'b1; else state_nx = S_READ;
                        default: state_nx = S_SYNC;
                    endcase
                end
            end
            S_CMD: begin
                cmd        = cmd_q;
                cmd_hasAny = 1'b1;
                if (cmd_consume) begin
                    state_nx = S_IDLE;
                    done     = 1'b1;
                end
            end
            S_WRITE: begin
                core_in            = host_in;
                core_in_isReady    = host_in_isReady;
                host_in_canReceive = core_in_canReceive;
                word_xfer          = host_in_isReady & core_in_canReceive;
                if (word_xfer && remaining == CNT_W'(1)) begin
                    state_nx = S_IDLE;
                    done     = 1'b1;
                end
            end
            S_READ: begin
                host_out            = core_out;
                host_out_isReady    = core_out_isReady;
                core_out_canReceive = host_out_canReceive;
                word_xfer           = core_out_isReady & host_out_canReceive;
                if (word_xfer && remaining == CNT_W'(1)) begin
                    state_nx = S_IDLE;
                    done     = 1'b1;
                end
            end
            S_SYNC: begin
                host_out         = {16'hA5A5, 16'h0000, 16'h0000, txn_count};
                host_out_isReady = 1'b1;
                if (host_out_canReceive) begin
                    state_nx = S_IDLE;
                    done     = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cmd_q     <= '0;
            remaining <= '0;
            txn_count <= '0;
        end else begin
            state <= state_nx;
            if (hdr_take) begin
                cmd_q     <= host_in[CMD_W-1:0];
                remaining <= hdr_count;
            end else if (word_xfer) begin
                remaining <= remaining - CNT_W'(1);
            end
            if (done) begin
                txn_count <= txn_count + 16'd1;
            end
        end
    end

endmodule
